soc_ctrl_top: RTL and testbench

UART-driven control subsystem of the LoongArch SoC top level. It receives byte commands on the board serial line and uses them to drive the 8 user LEDs and to perform SPI byte transfers to the SD card. It returns one reply byte per command. DDR3 and JTAG logic are separate blocks and are not part of this one.

---
 rtl/soc_ctrl_pkg.sv | 9 +
 rtl/soc_ctrl_uart.sv | 79 +++++++
 rtl/soc_ctrl_top.sv | 102 ++++++++++
 tb/tb_soc_ctrl_top.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/soc_ctrl_pkg.sv
// soc_ctrl_pkg: shared state, command and reply definitions for the UART control block
package soc_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ARG, SPI, REPLY} state_t;
  localparam logic [7:0] CMD_LED = 8'h4C;
  localparam logic [7:0] CMD_CS = 8'h43;
  localparam logic [7:0] CMD_SPI = 8'h53;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
endpackage

// File: rtl/soc_ctrl_uart.sv
// uart_core: 8N1 UART receiver with input synchronizer and transmitter
module uart_core #(
  parameter int BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);
  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);
  logic s1, s2, s3, rx_act, tx_act;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [3:0] rx_bit, tx_bit;
  logic [8:0] tx_sh;
  assign tx_busy = tx_act | tx_start;
  always_ff @(posedge clk) begin
    if (rst) begin
      {s3, s2, s1} <= 3'b111;
      rx_act <= 1'b0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, rx};
      rx_valid <= 1'b0;
      if (!rx_act) begin
        if (s3 & ~s2) begin
          rx_act <= 1'b1;
          rx_cnt <= HALF;
          rx_bit <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= FULL;
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == 4'd0) rx_act <= ~s2;
        else if (rx_bit == 4'd9) begin
          rx_act <= 1'b0;
          rx_valid <= s2;
        end else rx_byte <= {s2, rx_byte[7:1]};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= 1'b1;
      tx_act <= 1'b0;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '1;
    end else if (tx_start && !tx_act) begin
      tx <= 1'b0;
      tx_act <= 1'b1;
      tx_cnt <= FULL;
      tx_bit <= '0;
      tx_sh <= {1'b1, tx_data};
    end else if (tx_act) begin
      if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
      else begin
        tx_cnt <= FULL;
        tx_bit <= tx_bit + 1'b1;
        if (tx_bit == 4'd9) tx_act <= 1'b0;
        else begin
          tx <= tx_sh[0];
          tx_sh <= {1'b1, tx_sh[8:1]};
        end
      end
    end
  end
endmodule

// File: rtl/soc_ctrl_top.sv
// soc_ctrl_top: UART command interpreter driving LEDs and SD card SPI byte transfers
module soc_ctrl_top
  import soc_ctrl_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int SPI_DIV = 64
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       RsRx,
  output logic       RsTx,
  output logic [7:0] led,
  input  logic       sd_miso,
  output logic       sd_clk,
  output logic       sd_cs,
  output logic       sd_mosi
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int SW = $clog2(SPI_DIV);
  localparam logic [SW-1:0] SPI_LAST = SW'(SPI_DIV - 1);
  state_t state, nxt;
  logic rx_valid, tx_start, tx_busy, sent, spi_done, is_cmd, miso_s1, miso_s2;
  logic [7:0] rx_byte, cmd, reply, spi_sh;
  logic [SW-1:0] spi_cnt;
  logic [2:0] spi_bit;
  uart_core #(.BIT_CYC(BIT_CYC)) u_uart (
    .clk(sys_clk),
    .rst(sys_reset),
    .rx(RsRx),
    .tx_start(tx_start),
    .tx_data(reply),
    .tx(RsTx),
    .tx_busy(tx_busy),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte)
  );
  assign is_cmd = (rx_byte == CMD_LED) || (rx_byte == CMD_CS) || (rx_byte == CMD_SPI);
  assign spi_done = (state == SPI) && (spi_cnt == '0) && sd_clk && (spi_bit == 3'd7);
  assign tx_start = (state == REPLY) && !sent;
  always_ff @(posedge sys_clk) begin
    state <= sys_reset ? IDLE : nxt;
  end
  always_comb begin
    nxt = (state == IDLE && rx_valid) ? (is_cmd ? ARG : REPLY)
        : (state == ARG && rx_valid) ? ((cmd == CMD_SPI) ? SPI : REPLY)
        : spi_done ? REPLY
        : (state == REPLY && sent && !tx_busy) ? IDLE
        : state;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      led <= 8'h00;
      sd_cs <= 1'b1;
      sd_clk <= 1'b0;
      sd_mosi <= 1'b1;
      cmd <= '0;
      reply <= '0;
      spi_sh <= '0;
      spi_cnt <= '0;
      spi_bit <= '0;
      sent <= 1'b0;
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= sd_miso;
      miso_s2 <= miso_s1;
      sent <= (state == REPLY);
      if (state == IDLE && rx_valid) begin
        cmd <= rx_byte;
        reply <= RSP_ERR;
      end
      if (state == ARG && rx_valid) begin
        reply <= RSP_OK;
        if (cmd == CMD_LED) led <= rx_byte;
        if (cmd == CMD_CS) sd_cs <= rx_byte[0];
        if (cmd == CMD_SPI) begin
          spi_sh <= rx_byte;
          sd_mosi <= rx_byte[7];
          sd_clk <= 1'b0;
          spi_cnt <= SPI_LAST;
          spi_bit <= '0;
        end
      end
      if (state == SPI) begin
        if (spi_cnt != '0) spi_cnt <= spi_cnt - 1'b1;
        else begin
          spi_cnt <= SPI_LAST;
          sd_clk <= ~sd_clk;
          if (!sd_clk) spi_sh <= {spi_sh[6:0], miso_s2};
          else if (spi_bit == 3'd7) begin
            sd_mosi <= 1'b1;
            reply <= spi_sh;
          end else begin
            spi_bit <= spi_bit + 1'b1;
            sd_mosi <= spi_sh[7];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_soc_ctrl_top.sv
// tb_soc_ctrl_top: directed self-checking bench for the UART control subsystem
module tb_soc_ctrl_top;
  localparam int BC = 16;
  logic sys_clk = 1'b0, sys_reset = 1'b1, RsRx = 1'b1;
  logic RsTx, sd_clk, sd_cs, sd_mosi, sd_miso;
  logic [7:0] led;
  int checks = 0, errors = 0;
  logic [7:0] mosi_cap = '0;
  int run = 0, hi_len = 0, lo_len = 0;
  logic clk_q = 1'b0, seen_fall = 1'b0;
  logic [7:0] r;
  logic ok;
  assign sd_miso = sd_mosi;
  always #5 sys_clk = ~sys_clk;
  soc_ctrl_top #(.CLK_FREQ(1_843_200), .BAUD(115200), .SPI_DIV(64)) dut (
    .sys_clk(sys_clk),
    .sys_reset(sys_reset),
    .RsRx(RsRx),
    .RsTx(RsTx),
    .led(led),
    .sd_miso(sd_miso),
    .sd_clk(sd_clk),
    .sd_cs(sd_cs),
    .sd_mosi(sd_mosi)
  );
  always @(posedge sys_clk) begin
    if (sd_clk !== clk_q) begin
      if (clk_q) begin
        hi_len <= run;
        seen_fall <= 1'b1;
      end else begin
        if (seen_fall) lo_len <= run;
        mosi_cap <= {mosi_cap[6:0], sd_mosi};
      end
      run <= 1;
    end else run <= run + 1;
    clk_q <= sd_clk;
  end
  initial begin
    repeat (60000) @(posedge sys_clk);
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
    end
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_rstx"}, 8'(RsTx), 8'h01);
    chk({tag, "_led"}, led, 8'h00);
    chk({tag, "_cs"}, 8'(sd_cs), 8'h01);
    chk({tag, "_sclk"}, 8'(sd_clk), 8'h00);
    chk({tag, "_mosi"}, 8'(sd_mosi), 8'h01);
  endtask
  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    RsRx = 1'b0;
    tick(BC);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      tick(BC);
    end
    RsRx = stop;
    tick(BC);
    RsRx = 1'b1;
    if (!stop) tick(BC);
  endtask
  task automatic recv(output logic [7:0] b, output logic good, input int limit = 3000);
    int t = 0;
    b = '0;
    good = 1'b0;
    while (RsTx === 1'b1 && t < limit) begin
      tick(1);
      t++;
    end
    if (RsTx !== 1'b0) return;
    tick(BC / 2);
    if (RsTx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      tick(BC);
      b[i] = RsTx;
    end
    tick(BC);
    good = RsTx;
    tick(BC / 2 + 2);
  endtask
  initial begin
    tick(5);
    rst_chk("reset");
    sys_reset = 1'b0;
    tick(3);
    send(8'h4C);
    fork
      send(8'hA5);
      recv(r, ok);
    join
    chk("led_ok", 8'(ok), 8'h01);
    chk("led_reply", r, 8'h4B);
    chk("led_val", led, 8'hA5);
    send(8'h43);
    fork
      send(8'h00);
      recv(r, ok);
    join
    chk("cs_reply", r, 8'h4B);
    chk("cs_low", 8'(sd_cs), 8'h00);
    send(8'h53);
    fork
      begin
        send(8'h3C);
        send(8'h4C);
      end
      recv(r, ok);
    join
    chk("spi_ok", 8'(ok), 8'h01);
    chk("spi_reply", r, 8'h3C);
    chk("spi_mosi_bits", mosi_cap, 8'h3C);
    chk("spi_hi_len", 8'(hi_len), 8'd64);
    chk("spi_lo_len", 8'(lo_len), 8'd64);
    chk("spi_end_sclk", 8'(sd_clk), 8'h00);
    chk("spi_end_mosi", 8'(sd_mosi), 8'h01);
    chk("spi_cs_kept", 8'(sd_cs), 8'h00);
    fork
      send(8'h41);
      recv(r, ok);
    join
    chk("unk_reply", r, 8'h3F);
    send(8'h4C);
    fork
      send(8'h01);
      recv(r, ok);
    join
    chk("led2_reply", r, 8'h4B);
    chk("led2_val", led, 8'h01);
    fork
      send(8'h4C, 1'b0);
      recv(r, ok, 400);
    join
    chk("frame_no_reply", 8'(ok), 8'h00);
    chk("frame_led", led, 8'h01);
    fork
      send(8'h41);
      recv(r, ok);
    join
    chk("frame_next_reply", r, 8'h3F);
    chk("frame_next_led", led, 8'h01);
    send(8'h53);
    send(8'hF0);
    tick(200);
    chk("midspi_cs", 8'(sd_cs), 8'h00);
    sys_reset = 1'b1;
    tick(1);
    rst_chk("midspi");
    sys_reset = 1'b0;
    tick(3);
    send(8'h41);
    chk("midtx_start", 8'(RsTx), 8'h00);
    sys_reset = 1'b1;
    tick(1);
    rst_chk("midtx");
    sys_reset = 1'b0;
    tick(3);
    send(8'h4C);
    fork
      send(8'hFF);
      recv(r, ok);
    join
    chk("post_reply", r, 8'h4B);
    chk("post_led", led, 8'hFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
